// File: rtl/control_unit.sv
// control_unit: multicycle fetch/decode/execute sequencer for the 16-bit accumulator processor
module control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  output logic [1:0] SrcA,
  output logic [2:0] SrcB,
  output logic [2:0] ALUOP,
  output logic [1:0] AddrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ACCWrite,
  output logic       SPWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       ACCSrc,
  output logic [3:0] State,
  output logic       Halted
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMRD  = 4'd2,
    LOADWB = 4'd3,
    ALUEX  = 4'd4,
    ALUWB  = 4'd5,
    STORE  = 4'd6,
    BRANCH = 4'd7,
    JUMP   = 4'd8,
    PUSH1  = 4'd9,
    PUSH2  = 4'd10,
    POP1   = 4'd11,
    POP2   = 4'd12,
    HALT   = 4'd15
  } state_e;
  logic [3:0] st, nxt;
  always_ff @(posedge CLK)
    st <= Reset ? FETCH : nxt;
  assign State = st;
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE:
        case (Opcode)
          4'h0, 4'h2, 4'h3, 4'h4, 4'h5: nxt = MEMRD;
          4'h1:    nxt = STORE;
          4'h6:    nxt = ALUEX;
          4'h7:    nxt = BRANCH;
          4'h8:    nxt = JUMP;
          4'h9:    nxt = PUSH1;
          4'hA:    nxt = POP1;
          4'hF:    nxt = HALT;
          default: nxt = FETCH;
        endcase
      MEMRD:  nxt = (Opcode == 4'h0) ? LOADWB : ALUEX;
      ALUEX:  nxt = ALUWB;
      PUSH1:  nxt = PUSH2;
      POP1:   nxt = POP2;
      HALT:   nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  // Outputs are held at zero for the whole reset cycle so no write can complete.
  always_comb begin
    SrcA = 2'b00;
    SrcB = 3'b000;
    ALUOP = 3'b000;
    AddrSrc = 2'b00;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MDRWrite = 1'b0;
    ACCWrite = 1'b0;
    SPWrite = 1'b0;
    PCWrite = 1'b0;
    PCSrc = 1'b0;
    ACCSrc = 1'b0;
    Halted = 1'b0;
    if (!Reset)
      case (st)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        DECODE: SrcB = 3'b100;
        MEMRD: begin
          AddrSrc = 2'b01;
          MemRead = 1'b1;
          MDRWrite = 1'b1;
        end
        LOADWB: ACCWrite = 1'b1;
        ALUEX: begin
          SrcA = 2'b01;
          SrcB = (Opcode == 4'h6) ? 3'b001 : 3'b010;
          ALUOP = (Opcode == 4'h3) ? 3'b001 :
                  (Opcode == 4'h4) ? 3'b010 :
                  (Opcode == 4'h5) ? 3'b011 : 3'b000;
        end
        ALUWB: begin
          ACCWrite = 1'b1;
          ACCSrc = 1'b1;
        end
        STORE: begin
          AddrSrc = 2'b01;
          MemWrite = 1'b1;
        end
        BRANCH: begin
          SrcA = 2'b01;
          ALUOP = 3'b101;
          PCSrc = 1'b1;
          PCWrite = Zero;
        end
        JUMP: begin
          PCWrite = 1'b1;
          PCSrc = 1'b1;
        end
        PUSH1: begin
          SrcA = 2'b10;
          ALUOP = 3'b001;
          SPWrite = 1'b1;
        end
        PUSH2: begin
          AddrSrc = 2'b10;
          MemWrite = 1'b1;
        end
        POP1: begin
          AddrSrc = 2'b10;
          MemRead = 1'b1;
          MDRWrite = 1'b1;
        end
        POP2: begin
          SrcA = 2'b10;
          SPWrite = 1'b1;
          ACCWrite = 1'b1;
        end
        HALT: Halted = 1'b1;
        default: ;
      endcase
  end
endmodule
